// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the fetch/memory pipeline stages and the unified memory.
// The slave modport is the arbiter's view; master is the surrounding core and memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_rdata, if_valid, if_stall,
        output d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_rdata, if_valid, if_stall,
        input  d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage:
// data has priority, fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D} state_t;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    state_t      r_state,      w_state_next;
    logic [3:0]  r_starve_cnt, w_starve_next;
    logic        r_discard,    w_discard_next;
    logic        r_mem_req,    w_mem_req_next;
    logic        r_mem_we,     w_mem_we_next;
    logic [31:0] r_mem_addr,   w_mem_addr_next;
    logic [31:0] r_mem_wdata,  w_mem_wdata_next;
    logic [3:0]  r_mem_wstrb,  w_mem_wstrb_next;
    logic [31:0] r_if_rdata,   w_if_rdata_next;
    logic        r_if_valid,   w_if_valid_next;
    logic [31:0] r_d_rdata,    w_d_rdata_next;
    logic        r_d_valid,    w_d_valid_next;

    logic w_returning;
    logic w_grant_d;
    logic w_grant_i;

    // While a valid pulse is out, the requester still holds req for the finished
    // access; that cycle must not be mistaken for a new request.
    assign w_returning = r_if_valid | r_d_valid;
    assign w_grant_d   = bus.d_req & ~(bus.if_req & (r_starve_cnt == LIMIT)) & ~w_returning;
    assign w_grant_i   = ~w_grant_d & bus.if_req & ~bus.if_flush & ~w_returning;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
            r_discard    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_wstrb  <= 4'd0;
            r_if_rdata   <= 32'd0;
            r_if_valid   <= 1'b0;
            r_d_rdata    <= 32'd0;
            r_d_valid    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_discard    <= w_discard_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_mem_wstrb  <= w_mem_wstrb_next;
            r_if_rdata   <= w_if_rdata_next;
            r_if_valid   <= w_if_valid_next;
            r_d_rdata    <= w_d_rdata_next;
            r_d_valid    <= w_d_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_starve_next    = r_starve_cnt;
        w_discard_next   = r_discard;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_wstrb_next = r_mem_wstrb;
        w_if_rdata_next  = r_if_rdata;
        w_if_valid_next  = 1'b0;
        w_d_rdata_next   = r_d_rdata;
        w_d_valid_next   = 1'b0;

        case (r_state)
            IDLE: begin
                if (!bus.if_req) begin
                    w_starve_next = 4'd0;
                end
                if (w_grant_d) begin
                    w_state_next     = ISSUE_D;
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = bus.d_we;
                    w_mem_addr_next  = bus.d_addr;
                    w_mem_wdata_next = bus.d_we ? bus.d_wdata : 32'd0;
                    w_mem_wstrb_next = bus.d_we ? bus.d_wstrb : 4'd0;
                    if (bus.if_req && (r_starve_cnt != LIMIT)) begin
                        w_starve_next = r_starve_cnt + 4'd1;
                    end
                end else if (w_grant_i) begin
                    w_state_next     = ISSUE_I;
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = 1'b0;
                    w_mem_addr_next  = bus.if_addr;
                    w_mem_wdata_next = 32'd0;
                    w_mem_wstrb_next = 4'd0;
                    w_starve_next    = 4'd0;
                end
            end
            ISSUE_I: begin
                if (bus.mem_ready) begin
                    w_state_next   = WAIT_I;
                    w_mem_req_next = 1'b0;
                    w_discard_next = bus.if_flush;
                end else if (bus.if_flush) begin
                    w_state_next   = IDLE;
                    w_mem_req_next = 1'b0;
                end
            end
            WAIT_I: begin
                if (bus.mem_rvalid) begin
                    w_state_next   = IDLE;
                    w_discard_next = 1'b0;
                    if (!(r_discard || bus.if_flush)) begin
                        w_if_rdata_next = bus.mem_rdata;
                        w_if_valid_next = 1'b1;
                    end
                end else if (bus.if_flush) begin
                    w_discard_next = 1'b1;
                end
            end
            ISSUE_D: begin
                if (bus.mem_ready) begin
                    w_state_next   = WAIT_D;
                    w_mem_req_next = 1'b0;
                end
            end
            WAIT_D: begin
                if (bus.mem_rvalid) begin
                    w_state_next   = IDLE;
                    w_d_valid_next = 1'b1;
                    if (!r_mem_we) begin
                        w_d_rdata_next = bus.mem_rdata;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = r_d_valid;

    // Stalls are gated by reset so every output reads 0 while rst is low.
    assign bus.if_stall = rst & bus.if_req & ~r_if_valid & ~bus.if_flush;
    assign bus.d_stall  = rst & bus.d_req & ~r_d_valid;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction port) and the memory stage (data port) of the 5-stage RV32IM core.
- Data wins by fixed priority, with a starvation guard for fetch.
- Registers the request toward memory, tracks one outstanding transaction, returns read data or write acknowledge to the winning port, and drives per-port stall signals to the hazard unit.
- Fetch requests can be cancelled by a branch/jump flush.

Parameters:
STARVE_LIMIT, 4, consecutive data grants while a fetch is pending before fetch is forced to win (1..15).

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
if_req  input  1  fetch request, held until if_valid or if_flush
if_addr  input  32  fetch address (word aligned)
if_flush  input  1  cancel pending/outstanding fetch (jump_en from execute)
if_rdata  output  32  instruction returned
if_valid  output  1  one-cycle pulse, if_rdata valid
if_stall  output  1  fetch waiting; gates pc_en / IF-ID enable
d_req  input  1  data request, held until d_valid
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_wdata  input  32  store data, pre-aligned
d_wstrb  input  4  byte enables for store
d_rdata  output  32  load data returned (raw word)
d_valid  output  1  one-cycle pulse, load data or store acknowledged
d_stall  output  1  data access waiting; freezes pipeline up to MEM
mem_req  output  1  request to memory
mem_we  output  1  write enable
mem_addr  output  32  address
mem_wdata  output  32  write data
mem_wstrb  output  4  byte enables (4'b0000 on reads)
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data / write ack valid
mem_rdata  input  32  read data

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE; all outputs 0; starve_cnt = 0; discard flag = 0. Reset mid-transaction abandons it; memory is reset by the same rst.
- FSM states: IDLE, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D.
- IDLE, arbitration evaluated every cycle:
  - data granted if d_req and not (if_req and starve_cnt == STARVE_LIMIT);
  - else fetch granted if if_req and not if_flush;
  - the granted address, data, strobe and we are latched into the mem_* registers.
- ISSUE_x: mem_req = 1 with stable mem_* fields; on mem_ready, go to WAIT_x and mem_req = 0 next cycle.
- WAIT_x: on mem_rvalid, capture mem_rdata to the port's rdata, pulse that port's valid for exactly 1 cycle, return to IDLE. mem_rvalid is ignored in IDLE/ISSUE states.
- Latency: request seen in IDLE at cycle N gives mem_req at N+1; with mem_ready at N+1 and mem_rvalid at N+2, valid is seen at N+3. Minimum 3 cycles.
- Back-to-back: the requester keeping req high in the cycle after valid is a new request, arbitrated in IDLE.
- starve_cnt:
  - +1, saturating at STARVE_LIMIT, on each data grant made while if_req is high;
  - cleared on every fetch grant and whenever if_req is low in IDLE.
- Stalls (combinational): if_stall = if_req & ~if_valid & ~if_flush; d_stall = d_req & ~d_valid.
- Flush:
  - IDLE: blocks the fetch grant that cycle.
  - ISSUE_I without mem_ready: back to IDLE, mem_req dropped.
  - ISSUE_I with mem_ready in the same cycle, or in WAIT_I: set the discard flag. The following mem_rvalid completes the transaction with if_valid suppressed and if_rdata unchanged; the flag is then cleared.
  - Flush never affects a data transaction.
- Simultaneous if_req and d_req with starve_cnt < STARVE_LIMIT: data wins.
- Store: mem_we = 1, mem_wstrb = d_wstrb; completion on mem_rvalid; d_rdata unchanged.
- Read: mem_wstrb = 0; mem_wdata is don't-care and is driven 0.

Test Plan:
- Single fetch if_addr = 0x100, memory returns 0x00500093 with 1-cycle ready and 1-cycle rvalid -> mem_req at N+1, if_valid pulse at N+3 with if_rdata = 0x00500093, if_stall high N..N+2.
- if_req and d_req (load 0x2000) both high in IDLE -> load issued first, d_valid, then fetch issued; if_stall stays high until its if_valid.
- STARVE_LIMIT = 2, if_req held and d_req held continuously -> grant order D, D, I, D, D, I.
- Fetch in WAIT_I, if_flush pulsed -> mem_rvalid consumed, no if_valid, FSM IDLE; next if_req for 0x200 completes normally.
- Store d_addr = 0x3004, d_wdata = 0xDEADBEEF, d_wstrb = 4'b0011, mem_ready delayed 3 cycles -> mem_req held with stable fields 3 cycles, mem_wstrb = 0011, d_valid on ack, d_rdata unchanged.
- rst driven low in WAIT_D -> all outputs 0 immediately; after release, a stray mem_rvalid is ignored and no valid pulse occurs.
